// File: rtl/rv_pipe_ctrl.sv
// RV32I 5-stage main control: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundles, hazards, forwarding.
// Optional feature macro: RV_PIPE_CTRL_FWD_EN (EX-stage forwarding; without it, RAW hazards stall).

module rv_pipe_fwd_sel #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              exm_rw,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              mwb_rw,
  input  logic [REG_AW-1:0] mwb_rd,
  output logic [1:0]        sel
);
  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    sel = 2'b00;
    if (exm_rw && exm_rd == src)      sel = 2'b10;
    else if (mwb_rw && mwb_rd == src) sel = 2'b01;
  end
endmodule

module rv_pipe_ctrl #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [6:0]         id_opcode,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_redirect,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_jalr,
  output logic               ex_a_pc,
  output logic               ex_illegal,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic [1:0]         wb_sel,
  output logic [REG_AW-1:0]  wb_rd
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
    logic               jump;
    logic               jalr;
    logic               a_pc;
    logic               illegal;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         wb_sel;
    logic               use_rs1;
    logic               use_rs2;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             c;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd;
  } memwb_t;

  ctrl_t  dec;
  idex_t  idex, idex_d;
  exmem_t exmem;
  memwb_t memwb;
  logic   stall;
  logic   idex_bubble;

  // ID decode; an invalid slot decodes to a bubble.
  always_comb begin
    dec = '0;
    if (id_valid) begin
      case (id_opcode)
        OP_R: begin
          dec.reg_write = 1'b1;
          dec.alu_op    = ALUOP_W'(3'b010);
          dec.use_rs1   = 1'b1;
          dec.use_rs2   = 1'b1;
        end
        OP_I: begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = ALUOP_W'(3'b011);
          dec.use_rs1   = 1'b1;
        end
        OP_LOAD: begin
          dec.alu_src   = 1'b1;
          dec.mem_read  = 1'b1;
          dec.reg_write = 1'b1;
          dec.wb_sel    = 2'b01;
          dec.use_rs1   = 1'b1;
        end
        OP_STORE: begin
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          dec.use_rs1   = 1'b1;
          dec.use_rs2   = 1'b1;
        end
        OP_BR: begin
          dec.branch    = 1'b1;
          dec.alu_op    = ALUOP_W'(3'b001);
          dec.use_rs1   = 1'b1;
          dec.use_rs2   = 1'b1;
        end
        OP_JAL: begin
          dec.jump      = 1'b1;
          dec.a_pc      = 1'b1;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.wb_sel    = 2'b10;
        end
        OP_JALR: begin
          dec.jump      = 1'b1;
          dec.jalr      = 1'b1;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.wb_sel    = 2'b10;
          dec.use_rs1   = 1'b1;
        end
        OP_LUI: begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = ALUOP_W'(3'b100);
        end
        OP_AUIPC: begin
          dec.a_pc      = 1'b1;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
      // x0 is never written, which also keeps it out of hazard/forward matching.
      if (id_rd == '0) dec.reg_write = 1'b0;
    end
  end

`ifdef RV_PIPE_CTRL_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign stall = idex.c.mem_read && (idex.rd != '0) &&
                 ((dec.use_rs1 && idex.rd == id_rs1) || (dec.use_rs2 && idex.rd == id_rs2));

  logic [1:0][REG_AW-1:0] ex_src;
  logic [1:0][1:0]        fwd_sel;
  assign ex_src = {idex.rs2, idex.rs1};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    rv_pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
      .src    (ex_src[g]),
      .exm_rw (exmem.reg_write),
      .exm_rd (exmem.rd),
      .mwb_rw (memwb.reg_write),
      .mwb_rd (memwb.rd),
      .sel    (fwd_sel[g])
    );
  end

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];
`else
  // No bypass: hold ID until every producer in EX or MEM has reached WB.
  logic [1:0][REG_AW-1:0] id_src;
  logic [1:0]             id_use;
  logic [1:0]             src_hit;
  assign id_src = {id_rs2, id_rs1};
  assign id_use = {dec.use_rs2, dec.use_rs1};

  for (genvar g = 0; g < 2; g++) begin : g_raw
    assign src_hit[g] = id_use[g] &&
                        ((idex.c.reg_write && idex.rd  == id_src[g]) ||
                         (exmem.reg_write  && exmem.rd == id_src[g]));
  end

  assign stall = |src_hit;
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;

  logic unused_ex_src;
  assign unused_ex_src = ^{idex.rs1, idex.rs2};
`endif

  logic unused_use;
  assign unused_use = idex.c.use_rs1 ^ idex.c.use_rs2;

  // A redirect kills the ID instruction, so it overrides any stall.
  assign idex_bubble = ex_redirect || stall;
  assign pc_write    = !rst_n || ex_redirect || !stall;
  assign ifid_write  = !rst_n || ex_redirect || !stall;
  assign ifid_flush  = rst_n && ex_redirect;

  always_comb begin
    idex_d = '0;
    if (!idex_bubble) begin
      idex_d.c   = dec;
      idex_d.rs1 = id_rs1;
      idex_d.rs2 = id_rs2;
      idex_d.rd  = id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      idex            <= idex_d;
      exmem.mem_read  <= idex.c.mem_read;
      exmem.mem_write <= idex.c.mem_write;
      exmem.reg_write <= idex.c.reg_write;
      exmem.wb_sel    <= idex.c.wb_sel;
      exmem.rd        <= idex.rd;
      memwb.reg_write <= exmem.reg_write;
      memwb.wb_sel    <= exmem.wb_sel;
      memwb.rd        <= exmem.rd;
    end
  end

  assign ex_alu_src   = idex.c.alu_src;
  assign ex_alu_op    = idex.c.alu_op;
  assign ex_branch    = idex.c.branch;
  assign ex_jump      = idex.c.jump;
  assign ex_jalr      = idex.c.jalr;
  assign ex_a_pc      = idex.c.a_pc;
  assign ex_illegal   = idex.c.illegal;
  assign mem_read     = exmem.mem_read;
  assign mem_write    = exmem.mem_write;
  assign wb_reg_write = memwb.reg_write;
  assign wb_sel       = memwb.wb_sel;
  assign wb_rd        = memwb.rd;

endmodule
